// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//
// Purpose:
//   Conditional-branch predictor and misprediction recovery controller.
//   A table of 2-bit saturating counters (the BHT) is looked up
//   combinationally with the fetch PC to give a taken prediction. It is
//   trained with the outcome of each branch resolved in execute. When the
//   carried-down prediction disagrees with the real outcome, the controller
//   issues a one-cycle fetch redirect with the corrected PC. It then squashes
//   the younger stages for FLUSH_CYCLES consecutive cycles. While that
//   recovery is in progress, execute-stage instructions are wrong-path and
//   are ignored.
//
// Parameters:
//   n            - PC / datapath width
//   BHT_DEPTH    - number of 2-bit counters (power of two, 4..64)
//   FLUSH_CYCLES - flush pulse length in cycles (1..7)
//
// Ports:
//   clk_i            in   rising-edge clock
//   rst_i            in   asynchronous active-high reset
//   fetch_pc_i       in   PC of the instruction in fetch
//   pred_taken_o     out  taken prediction for fetch_pc_i
//   ex_valid_i       in   execute-stage instruction valid
//   ex_is_branch_i   in   execute-stage instruction is a conditional branch
//   ex_pc_i          in   PC of the execute-stage branch
//   ex_pred_taken_i  in   prediction that travelled with that branch
//   en_jump_i        in   resolved branch outcome
//   ex_target_i      in   computed branch target
//   redirect_valid_o out  one-cycle fetch redirect strobe
//   redirect_pc_o    out  corrected fetch PC (meaningful with the strobe)
//   flush_o          out  squash younger pipeline stages
//   busy_o           out  high whenever a recovery sequence is in progress
//
// Optional feature (macro BRANCH_STATS_EN):
//   Defining BRANCH_STATS_EN adds br_count_o and mispred_count_o. These are
//   32-bit wrapping counts of resolved branches and of mispredicts.
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
    parameter int n            = 32,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [n-1:0] fetch_pc_i,
    output logic         pred_taken_o,
    input  logic         ex_valid_i,
    input  logic         ex_is_branch_i,
    input  logic [n-1:0] ex_pc_i,
    input  logic         ex_pred_taken_i,
    input  logic         en_jump_i,
    input  logic [n-1:0] ex_target_i,
    output logic         redirect_valid_o,
    output logic [n-1:0] redirect_pc_o,
    output logic         flush_o,
`ifdef BRANCH_STATS_EN
    output logic         busy_o,
    output logic [31:0]  br_count_o,
    output logic [31:0]  mispred_count_o
`else
    output logic         busy_o
`endif
);

    localparam int         IDX_W      = $clog2(BHT_DEPTH);
    localparam logic [2:0] FLUSH_LEFT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t           state_q;
    logic             redirect_valid_q;
    logic             flush_q;
    logic             busy_q;
    logic [n-1:0]     redirect_pc_q;
    logic [2:0]       flush_cnt_q;
    logic [1:0]       bht_q [BHT_DEPTH];

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             resolve;
    logic             mispredict;
    logic [1:0]       ctr_d;
    logic [n-1:0]     fix_pc;
    logic             unused_fetch_bits;

    // Instructions are word aligned, so the two lowest PC bits carry no
    // information. The BHT index starts at bit 2. Lookup and training use
    // the same slice, so a branch always trains the entry it was predicted
    // from.
    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign ex_idx    = ex_pc_i[IDX_W+1:2];

    // The fetch PC bits outside the index are intentionally ignored. Tags
    // are not kept, so aliasing between branches is accepted.
    assign unused_fetch_bits = ^{fetch_pc_i[n-1:IDX_W+2], fetch_pc_i[1:0]};

    // The prediction reads the registered table directly. A lookup in the
    // same cycle as an update to the same entry therefore sees the value
    // from before that update.
    assign pred_taken_o = bht_q[fetch_idx][1];

    // A branch counts as resolved only while the controller is idle. During
    // redirect/flush, the execute stage holds wrong-path work that must
    // neither train the table nor trigger another redirect.
    assign resolve    = ex_valid_i & ex_is_branch_i & (state_q == IDLE);
    assign mispredict = resolve & (en_jump_i ^ ex_pred_taken_i);

    // The corrected fetch address is the branch target when the branch
    // really was taken. Otherwise it is the fall-through instruction, and
    // the addition wraps naturally at the PC width.
    assign fix_pc = en_jump_i ? ex_target_i : (ex_pc_i + n'(4));

    // Next value of the trained counter. It moves one step toward the
    // observed outcome and saturates at both ends, so a single anomalous
    // outcome cannot flip a strongly biased entry.
    always_comb begin
        ctr_d = bht_q[ex_idx];
        if (en_jump_i) begin
            if (ctr_d != 2'b11) begin
                ctr_d = ctr_d + 2'b01;
            end
        end else begin
            if (ctr_d != 2'b00) begin
                ctr_d = ctr_d - 2'b01;
            end
        end
    end

    // Branch history table. Reset puts every entry in weakly-not-taken, so
    // one taken outcome is enough to start predicting taken. Only resolved
    // branches train it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolve) begin
            bht_q[ex_idx] <= ctr_d;
        end
    end

    // Recovery sequencer. A mispredict in IDLE latches the corrected PC and
    // enters REDIRECT. REDIRECT strobes the redirect for exactly one cycle
    // and is the first flush cycle. FLUSH then supplies the remaining
    // FLUSH_CYCLES-1 flush cycles. With a one-cycle flush, FLUSH is skipped.
    // All outputs are registered here alongside the state. Reset abandons
    // any sequence in progress, so no stale pulse can follow release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            redirect_pc_q    <= '0;
            flush_cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispredict) begin
                        state_q          <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                        flush_q          <= 1'b1;
                        busy_q           <= 1'b1;
                        redirect_pc_q    <= fix_pc;
                    end
                end
                REDIRECT: begin
                    redirect_valid_q <= 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= FLUSH_LEFT;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q <= 3'd1) begin
                        state_q     <= IDLE;
                        flush_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign busy_o           = busy_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;

    // Performance counters. They count only branches that were actually
    // resolved, so wrong-path branches seen during recovery are excluded.
    // Both counters wrap silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (resolve) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mispredict) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign br_count_o      = br_count_q;
    assign mispred_count_o = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
//
// Directed bench for branch_predict_ctrl. When a mispredicting branch is
// issued, its corrected PC is queued. A monitor pops the queue whenever the
// DUT strobes redirect_valid_o, and it also measures each flush pulse. The
// main thread drives branches and checks predictions, counters and reset
// behaviour. The br_count_o / mispred_count_o checks exist only when
// BRANCH_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

    localparam int N            = 32;
    localparam int BHT_DEPTH    = 16;
    localparam int FLUSH_CYCLES = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] fetch_pc_i;
    logic         pred_taken_o;
    logic         ex_valid_i;
    logic         ex_is_branch_i;
    logic [N-1:0] ex_pc_i;
    logic         ex_pred_taken_i;
    logic         en_jump_i;
    logic [N-1:0] ex_target_i;
    logic         redirect_valid_o;
    logic [N-1:0] redirect_pc_o;
    logic         flush_o;
    logic         busy_o;
`ifdef BRANCH_STATS_EN
    logic [31:0]  br_count_o;
    logic [31:0]  mispred_count_o;
`endif

    int           checksTotal  = 0;
    int           checksPassed = 0;
    logic [N-1:0] expRedirectQ [$];
    int           flushRun     = 0;

    branch_predict_ctrl #(
        .n           (N),
        .BHT_DEPTH   (BHT_DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fetch_pc_i      (fetch_pc_i),
        .pred_taken_o    (pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_is_branch_i  (ex_is_branch_i),
        .ex_pc_i         (ex_pc_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .en_jump_i       (en_jump_i),
        .ex_target_i     (ex_target_i),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
`ifdef BRANCH_STATS_EN
        .busy_o          (busy_o),
        .br_count_o      (br_count_o),
        .mispred_count_o (mispred_count_o)
`else
        .busy_o          (busy_o)
`endif
    );

    // Free-running clock. Rising edges fall at 5, 15, 25, ... so that all
    // driving and sampling happens on the falling edge.
    always #5 clk_i = ~clk_i;

    // A single comparison point. Every comparison in the bench goes through
    // this task, so it owns both counters.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one execute-stage branch (called on a falling edge), with the
    // same PC also in fetch. It checks the combinational prediction before
    // the resolve edge and queues the expected redirect PC when a mispredict
    // is intended. It returns on the falling edge just after the resolve
    // edge.
    task automatic applyStimulus(input logic [N-1:0] pc, input logic predIn,
                                 input logic taken, input logic [N-1:0] target,
                                 input logic expPredNow, input logic expRedirect,
                                 input logic [N-1:0] expPc);
        fetch_pc_i      = pc;
        ex_valid_i      = 1'b1;
        ex_is_branch_i  = 1'b1;
        ex_pc_i         = pc;
        ex_pred_taken_i = predIn;
        en_jump_i       = taken;
        ex_target_i     = target;
        if (expRedirect) begin
            expRedirectQ.push_back(expPc);
        end
        #1;
        checkOutput("predTakenLookup", {31'd0, pred_taken_o}, {31'd0, expPredNow});
        @(posedge clk_i);
        @(negedge clk_i);
        ex_valid_i     = 1'b0;
        ex_is_branch_i = 1'b0;
    endtask

    // Waits a bounded number of cycles for the recovery sequence to finish.
    // Running out of cycles is recorded as a failure.
    task automatic waitIdle();
        int cycles = 0;
        while (busy_o && cycles < 20) begin
            @(negedge clk_i);
            cycles++;
        end
        checkOutput("idleTimeout", {31'd0, busy_o}, 32'd0);
    endtask

    // Monitor. Each redirect strobe must match the oldest queued corrected
    // PC. Each flush pulse must last exactly FLUSH_CYCLES cycles. Pulses
    // interrupted by reset are discarded.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                flushRun = 0;
            end else begin
                if (redirect_valid_o) begin
                    if (expRedirectQ.size() == 0) begin
                        checkOutput("unexpectedRedirect", 32'd1, 32'd0);
                    end else begin
                        checkOutput("redirectPc", redirect_pc_o, expRedirectQ.pop_front());
                    end
                end
                if (flush_o) begin
                    flushRun++;
                end else if (flushRun != 0) begin
                    checkOutput("flushLength", flushRun, FLUSH_CYCLES);
                    flushRun = 0;
                end
            end
        end
    end

    // Directed sequence. The expected counter values and PCs were worked out
    // by hand from the index slice PC[5:2] with the 16-entry table.
    initial begin
        logic seen;
        rst_i           = 1'b1;
        fetch_pc_i      = 32'h40;
        ex_valid_i      = 1'b0;
        ex_is_branch_i  = 1'b0;
        ex_pc_i         = '0;
        ex_pred_taken_i = 1'b0;
        en_jump_i       = 1'b0;
        ex_target_i     = '0;
        seen            = 1'b0;

        repeat (2) @(negedge clk_i);
        checkOutput("rstRedirectValid", {31'd0, redirect_valid_o}, 32'd0);
        checkOutput("rstFlush", {31'd0, flush_o}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy_o}, 32'd0);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstPred40", {31'd0, pred_taken_o}, 32'd0);
        checkOutput("rstCtr0", {30'd0, dut.bht_q[0]}, 32'd1);
        checkOutput("rstCtr15", {30'd0, dut.bht_q[15]}, 32'd1);
        checkOutput("rstRedirectPc", redirect_pc_o, 32'd0);

        $display("[TB] taken mispredict at 0x40");
        applyStimulus(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100);
        checkOutput("ctr0AfterTaken", {30'd0, dut.bht_q[0]}, 32'd2);
        checkOutput("pred40AfterTaken", {31'd0, pred_taken_o}, 32'd1);
        checkOutput("busyInRedirect", {31'd0, busy_o}, 32'd1);
        waitIdle();

        $display("[TB] three correct taken predictions");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, '0);
            checkOutput("ctr0Saturate", {30'd0, dut.bht_q[0]}, 32'd3);
            checkOutput("busyAfterCorrect", {31'd0, busy_o}, 32'd0);
        end

        $display("[TB] not-taken mispredict at 0x40, wrong-path branch during flush");
        applyStimulus(32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h44);
        checkOutput("ctr0AfterNotTaken", {30'd0, dut.bht_q[0]}, 32'd2);
        @(negedge clk_i);
        checkOutput("flushStateFlush", {31'd0, flush_o}, 32'd1);
        checkOutput("flushStateBusy", {31'd0, busy_o}, 32'd1);
        checkOutput("flushStateNoStrobe", {31'd0, redirect_valid_o}, 32'd0);
        fetch_pc_i      = 32'h88;
        ex_valid_i      = 1'b1;
        ex_is_branch_i  = 1'b1;
        ex_pc_i         = 32'h88;
        ex_pred_taken_i = 1'b0;
        en_jump_i       = 1'b1;
        ex_target_i     = 32'h200;
        @(posedge clk_i);
        @(negedge clk_i);
        ex_valid_i     = 1'b0;
        ex_is_branch_i = 1'b0;
        checkOutput("ctr2WrongPath", {30'd0, dut.bht_q[2]}, 32'd1);
        checkOutput("idleAfterFlush", {31'd0, busy_o}, 32'd0);

        $display("[TB] fall-through wrap at top of address space");
        applyStimulus(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h500, 1'b0, 1'b1, 32'h0);
        waitIdle();
        checkOutput("ctr15AfterNotTaken", {30'd0, dut.bht_q[15]}, 32'd0);

        $display("[TB] reset during redirect strobe");
        applyStimulus(32'h48, 1'b1, 1'b0, 32'h600, 1'b0, 1'b1, 32'h4C);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("midRstRedirectValid", {31'd0, redirect_valid_o}, 32'd0);
        checkOutput("midRstFlush", {31'd0, flush_o}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy_o}, 32'd0);
        checkOutput("midRstRedirectPc", redirect_pc_o, 32'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("midRstCtr0", {30'd0, dut.bht_q[0]}, 32'd1);
        checkOutput("midRstCtr2", {30'd0, dut.bht_q[2]}, 32'd1);
        repeat (4) begin
            @(negedge clk_i);
            if (flush_o || redirect_valid_o) begin
                seen = 1'b1;
            end
        end
        checkOutput("postResetPulse", {31'd0, seen}, 32'd0);

        $display("[TB] five branches, two mispredicts");
        applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        applyStimulus(32'h44, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
        waitIdle();
        applyStimulus(32'h44, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, '0);
        applyStimulus(32'h4C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        applyStimulus(32'h40, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h10);
        waitIdle();
        checkOutput("statsCtr0", {30'd0, dut.bht_q[0]}, 32'd1);
        checkOutput("statsCtr1", {30'd0, dut.bht_q[1]}, 32'd3);
        checkOutput("statsCtr3", {30'd0, dut.bht_q[3]}, 32'd0);
`ifdef BRANCH_STATS_EN
        checkOutput("brCount", br_count_o, 32'd5);
        checkOutput("mispredCount", mispred_count_o, 32'd2);
`endif

        @(negedge clk_i);
        checkOutput("pendingRedirects", expRedirectQ.size(), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter n, default 32: datapath/PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 16: number of 2-bit history counters, power of two, 4..64.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2: flush pulse length in cycles, 1..7.
REQ-004 SHALL have port clk_i  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port fetch_pc_i  input  n: PC of the instruction in fetch.
REQ-007 SHALL have port pred_taken_o  output  1: taken prediction for fetch_pc_i.
REQ-008 SHALL have port ex_valid_i  input  1: execute-stage instruction valid.
REQ-009 SHALL have port ex_is_branch_i  input  1: execute-stage instruction is a conditional branch.
REQ-010 SHALL have port ex_pc_i  input  n: PC of the execute-stage branch.
REQ-011 SHALL have port ex_pred_taken_i  input  1: prediction carried down with that branch.
REQ-012 SHALL have port en_jump_i  input  1: resolved outcome from the branch condition unit.
REQ-013 SHALL have port ex_target_i  input  n: computed branch target.
REQ-014 SHALL have port redirect_valid_o  output  1: one-cycle fetch redirect strobe.
REQ-015 SHALL have port redirect_pc_o  output  n: corrected fetch PC, meaningful only with the strobe.
REQ-016 SHALL have port flush_o  output  1: squash younger pipeline stages.
REQ-017 SHALL have port busy_o  output  1: high whenever state is not IDLE.

Function
REQ-018 SHALL index the BHT with PC[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-019 SHALL drive pred_taken_o combinationally as bit 1 of the indexed counter (counter >= 2).
REQ-020 SHALL resolve a branch when ex_valid_i=1, ex_is_branch_i=1 and state=IDLE; mispredict = en_jump_i XOR ex_pred_taken_i.
REQ-021 SHALL update the indexed counter at the resolve edge: +1 saturating at 3 if en_jump_i=1, -1 saturating at 0 otherwise.
REQ-022 SHALL return the pre-update counter value on a same-cycle lookup/update to the same index.
REQ-023 SHALL, on a mispredict, latch redirect_pc_o = ex_target_i if en_jump_i=1, else ex_pc_i+4 (mod 2^n), and move to REDIRECT.
REQ-024 SHALL implement states IDLE, REDIRECT and FLUSH: IDLE->REDIRECT on mispredict; REDIRECT->FLUSH after exactly 1 cycle; FLUSH->IDLE after FLUSH_CYCLES-1 cycles; a FLUSH_CYCLES of 1 SHALL go REDIRECT->IDLE directly.
REQ-025 SHALL assert redirect_valid_o only in REDIRECT (exactly one cycle per mispredict).
REQ-026 SHALL assert flush_o in REDIRECT and FLUSH, for a total of FLUSH_CYCLES consecutive cycles.
REQ-027 SHALL ignore ex_valid_i while busy: no BHT update, no new redirect (wrong-path instructions).
REQ-028 SHALL leave BHT, state and outputs unchanged for a correctly predicted branch or a non-branch.

Reset
REQ-029 SHALL, while rst_i=1, immediately force state=IDLE, redirect_valid_o=0, flush_o=0, busy_o=0, redirect_pc_o=0, every BHT counter=2'b01.
REQ-030 SHALL abandon any in-progress redirect/flush on reset mid-sequence, with no pulse after deassertion.

Configuration
REQ-031 SHALL, with BRANCH_STATS_EN defined, add outputs br_count_o (32-bit, +1 per resolved branch) and mispred_count_o (32-bit, +1 per mispredict), both wrapping at 2^32 and reset to 0.
REQ-032 SHALL, without BRANCH_STATS_EN, omit both ports and their counters entirely.

Verification
REQ-033 SHALL cover: reset, fetch_pc_i=0x40 -> pred_taken_o=0; counters read 01.
REQ-034 SHALL cover: branch at 0x40, pred 0, en_jump_i=1, target 0x100 -> next cycle redirect_valid_o=1 with redirect_pc_o=0x100; flush_o high 2 cycles; counter 01->10.
REQ-035 SHALL cover: same branch taken 3 more times with correct predictions -> counter saturates at 11; no redirect; a not-taken outcome then gives 10 plus redirect to 0x44.
REQ-036 SHALL cover: a second mispredicting branch during FLUSH -> ignored; BHT unchanged; single redirect only.
REQ-037 SHALL cover: rst_i asserted in the cycle redirect_valid_o=1 -> all outputs 0 immediately; no flush after release.
REQ-038 SHALL cover: with BRANCH_STATS_EN, 5 branches including 2 mispredicts -> br_count_o=5, mispred_count_o=2.
